// File: rtl/debounce_pkg.sv
// Shared types and parameter legality helper for the debounce_sync input
// conditioning block.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW,
        CHK_HIGH,
        ST_HIGH,
        CHK_LOW
    } db_state_t;

    function automatic bit params_legal(input int sync_stages, input int debounce_cycles);
        return (sync_stages >= 2) && (debounce_cycles >= 1);
    endfunction

endpackage

// File: rtl/debounce_sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous bit into the clk domain.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            chain <= '0;
        else
            chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes a bouncing external input and filters it with a counter-based
// debounce FSM, producing a clean level plus one-cycle rise/fall pulses.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    if (!params_legal(SYNC_STAGES, DEBOUNCE_CYCLES)) begin : g_bad_params
        $error("debounce_sync: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic          sync_q;
    db_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          dout_nxt, rise_nxt, fall_nxt, busy_nxt;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (din),
        .q     (sync_q)
    );

    // Any disagreement during a check state aborts back to the stable state,
    // so a candidate edge must be seen DEBOUNCE_CYCLES edges in a row.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_LOW: begin
                if (sync_q) begin
                    cnt_nxt = CW'(1);
                    if (DEBOUNCE_CYCLES == 1) state_nxt = ST_HIGH;
                    else                      state_nxt = CHK_HIGH;
                end
            end
            CHK_HIGH: begin
                if (!sync_q) begin
                    state_nxt = ST_LOW;
                    cnt_nxt   = '0;
                end else if (int'(cnt) + 1 == DEBOUNCE_CYCLES) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_HIGH: begin
                if (!sync_q) begin
                    cnt_nxt = CW'(1);
                    if (DEBOUNCE_CYCLES == 1) state_nxt = ST_LOW;
                    else                      state_nxt = CHK_LOW;
                end
            end
            CHK_LOW: begin
                if (sync_q) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = '0;
                end else if (int'(cnt) + 1 == DEBOUNCE_CYCLES) begin
                    state_nxt = ST_LOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = ST_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they can be registered
    // alongside it; an aborted check never produces a pulse.
    always_comb begin
        dout_nxt = (state_nxt == ST_HIGH) || (state_nxt == CHK_LOW);
        busy_nxt = (state_nxt == CHK_HIGH) || (state_nxt == CHK_LOW);
        rise_nxt = (state_nxt == ST_HIGH) && ((state == CHK_HIGH) || (state == ST_LOW));
        fall_nxt = (state_nxt == ST_LOW)  && ((state == CHK_LOW)  || (state == ST_HIGH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_LOW;
            cnt   <= '0;
            dout  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dout  <= dout_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
            busy  <= busy_nxt;
        end
    end

endmodule

// File: doc/debounce_sync.md
# debounce_sync

Input conditioning stage that sits directly upstream of the design's D flip-flop and register stages. It takes an asynchronous, possibly bouncing external signal such as a push-button or switch. It synchronizes that signal into the `clk` domain and filters it with a counter-based debounce state machine. Its outputs are a clean level plus single-cycle rise/fall pulses, suitable as `d` inputs for downstream registers.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops; legal range ≥ 2.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before the output changes; legal range ≥ 1.
- `clk` input, 1 bit: clock; all state updates on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `din` input, 1 bit: raw asynchronous input.
- `dout` output, 1 bit: debounced level, registered.
- `rise` output, 1 bit: one-cycle pulse when `dout` goes 0→1, registered.
- `fall` output, 1 bit: one-cycle pulse when `dout` goes 1→0, registered.
- `busy` output, 1 bit: high while a candidate transition is being qualified.

## Operation
- Synchronizer: chain of `SYNC_STAGES` flops, all reset to 0; `sync_q` is the last stage.
- FSM states:
  - `ST_LOW`: `dout`=0.
  - `CHK_HIGH`: qualifying a 0→1 transition.
  - `ST_HIGH`: `dout`=1.
  - `CHK_LOW`: qualifying a 1→0 transition.
- Counter `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`, unsigned, reset 0.
- `ST_LOW`:
  - `sync_q`=1 → `cnt`=1.
  - If `DEBOUNCE_CYCLES`==1, go to `ST_HIGH` in the same edge.
  - Otherwise go to `CHK_HIGH`.
- `CHK_HIGH`:
  - `sync_q`=0 → `ST_LOW`, `cnt`=0 (abort, no output change).
  - `sync_q`=1 → `cnt`+1; when `cnt`+1 == `DEBOUNCE_CYCLES` → `ST_HIGH`, `cnt`=0.
- `ST_HIGH` and `CHK_LOW` mirror `ST_LOW` and `CHK_HIGH` with polarity inverted.
- `cnt` never exceeds `DEBOUNCE_CYCLES`; no wrap-around is possible.
- `dout` is 1 exactly in `ST_HIGH` and `CHK_LOW`, and is driven from a flop, not decoded combinationally.
- `rise`: asserted on the edge that enters `ST_HIGH` from `CHK_HIGH` or `ST_LOW`; deasserted on the next edge.
- `fall` is the same for entry into `ST_LOW` from `CHK_LOW` or `ST_HIGH`.
- `rise` and `fall` are never high simultaneously.
- `busy` = state ∈ {`CHK_HIGH`, `CHK_LOW`}, registered.
- Reset mid-operation:
  - All flops clear immediately: synchronizer, `cnt`, FSM→`ST_LOW`, `dout`/`rise`/`fall`/`busy`=0.
  - A partially qualified transition is discarded.

## Timing
- Reset values: `dout`=0, `rise`=0, `fall`=0, `busy`=0, FSM=`ST_LOW`. Asynchronous, with no clock required.
- Reset release: normal operation resumes from the first rising edge after deassertion.
- Latency: `din` stable from before edge 1 → `dout` and the pulse change at edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`. With defaults this is edge 6.
- Any `sync_q` disagreement during qualification restarts qualification from 0. The latency is then measured from the last `din` transition.
- Pulse width is exactly 1 `clk` cycle.
- Minimum spacing between a `rise` and the next `fall` is `DEBOUNCE_CYCLES` cycles.

## Structure
- Package `debounce_pkg`:
  - `typedef enum logic [1:0] {ST_LOW, CHK_HIGH, ST_HIGH, CHK_LOW} db_state_t`.
  - Elaboration check: `SYNC_STAGES` ≥ 2 and `DEBOUNCE_CYCLES` ≥ 1.
- Sub-module `sync_chain` (parameter `STAGES`; ports `clk`, `reset`, `d`, `q`): a flop shift chain, every stage with asynchronous active-high reset to 0.
- `debounce_sync` instantiates one `sync_chain`, plus the FSM, counter and output registers.

## Test plan
- Reset while `din`=1 → all outputs 0 immediately without a clock edge. Release, hold `din`=1 → `dout`=1 and `rise`=1 at edge 6, `rise`=0 at edge 7, `busy`=1 at edges 3–5.
- Glitch: `din`=1 for 3 cycles, then 0 → `dout` stays 0, no `rise`, `busy` returns to 0, FSM back in `ST_LOW`.
- Bounce: `din` toggles 1,0,1,0,1 on consecutive cycles, then stays 1 → exactly one `rise`, at edge 6 after the final 0→1 transition.
- Fall: from stable `dout`=1, drive `din`=0 → `fall` high for exactly one cycle at edge 6, `dout`=0, no `rise` at any point.
- Reset mid-qualification: assert `reset` in `CHK_HIGH` with `cnt`=2 → `cnt`, `busy` and synchronizer clear at once. After release with `din`=1, the full 6-edge latency applies again.
- Parameters `SYNC_STAGES`=3, `DEBOUNCE_CYCLES`=1 → `dout` rises at edge 4, `busy` never asserts.
